spi_display_window_streamer: RTL and testbench

Parametrised successor to the fixed full-screen ILI9341 pixel path. After panel init, it writes an arbitrary rectangular window: issues CASET/RASET/RAMWR over the byte-level SPI handshake, then streams pixels in a selectable format. Sits between the frame/pixel source and the SPI byte controller, and drives data_commandb, hsync and vsync.

---
 rtl/display_pkg.sv | 31 +++
 rtl/display_pixel_packer.sv | 62 ++++++
 rtl/spi_display_window_streamer.sv | 176 +++++++++++++++++
 tb/tb_spi_display_window_streamer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the ILI9341 window streamer.
package display_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic {PIX_RGB565 = 1'b0, PIX_RGB666 = 1'b1} pixel_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_CMD,
        ST_CASET_ARG,
        ST_RASET_CMD,
        ST_RASET_ARG,
        ST_RAMWR_CMD,
        ST_PIXELS
    } stream_state_t;

    // Byte idx of the 4-byte {lo, hi} address argument, MSB first.
    function automatic logic [7:0] arg_byte(input logic [15:0] lo, input logic [15:0] hi,
                                            input logic [1:0] idx);
        case (idx)
            2'd0:    arg_byte = lo[15:8];
            2'd1:    arg_byte = lo[7:0];
            2'd2:    arg_byte = hi[15:8];
            default: arg_byte = hi[7:0];
        endcase
    endfunction

endpackage

// File: rtl/display_pixel_packer.sv
// One-pixel holding register that serialises RGB888 into RGB565/RGB666 bytes.
module display_pixel_packer
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  pixel_mode_t mode,
    input  logic        allow,
    input  logic        final_px,
    input  logic        take,
    input  logic [23:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic        has_byte,
    output logic [7:0]  pix_byte,
    output logic        last_byte
);

    // Only the colour bits either format can ever send are kept.
    logic [17:0] hold;
    logic        full;
    logic [1:0]  idx;
    logic        unused_bits;

    assign unused_bits = ^{px_data[17:16], px_data[9:8], px_data[1:0]};
    assign last_byte   = (mode == PIX_RGB666) ? (idx == 2'd2) : (idx == 2'd1);
    assign has_byte    = full;
    // Refill in the same cycle the last byte leaves, unless it was the window's final pixel.
    assign px_ready    = allow && (!full || (take && last_byte && !final_px));

    always_comb begin
        pix_byte = 8'h00;
        if (mode == PIX_RGB666) begin
            case (idx)
                2'd0:    pix_byte = {hold[17:12], 2'b00};
                2'd1:    pix_byte = {hold[11:6], 2'b00};
                default: pix_byte = {hold[5:0], 2'b00};
            endcase
        end else begin
            pix_byte = (idx == 2'd0) ? {hold[17:13], hold[11:9]} : {hold[8:6], hold[5:1]};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold <= '0;
            full <= 1'b0;
            idx  <= 2'd0;
        end else begin
            if (take) begin
                idx <= last_byte ? 2'd0 : idx + 2'd1;
                if (last_byte) full <= 1'b0;
            end
            if (px_valid && px_ready) begin
                hold <= {px_data[23:18], px_data[15:10], px_data[7:2]};
                full <= 1'b1;
                idx  <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/spi_display_window_streamer.sv
// Writes a rectangular window to an ILI9341: CASET/RASET/RAMWR then pixel bytes.
module spi_display_window_streamer
    import display_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int CW             = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          ena,
    input  logic          start,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] y1,
    input  logic          pixel_mode,
    input  logic [23:0]   px_data,
    input  logic          px_valid,
    output logic          px_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          data_commandb,
    output logic          busy,
    output logic          hsync,
    output logic          vsync,
    output logic          err_window
);

    localparam logic [CW-1:0] X_MAX = CW'(DISPLAY_WIDTH - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(DISPLAY_HEIGHT - 1);

    stream_state_t state, state_nx;
    pixel_mode_t   mode_q;
    logic [CW-1:0] x0_q, x1_q, y0_q, y1_q, w_span, h_span, col, row;
    logic [1:0]    arg_idx;
    logic          done, tx_eol, tx_eof;
    logic          legal, take_start, can_load, src_avail, launch, accept;
    logic          row_end, win_end, in_pix;
    logic [7:0]    src_byte;
    logic          src_dc;
    logic          pk_has, pk_last;
    logic [7:0]    pk_byte;

    assign legal      = (x0 <= x1) && (x1 <= X_MAX) && (y0 <= y1) && (y1 <= Y_MAX);
    // A start landing on the vsync cycle belongs to the window that is just closing.
    assign take_start = (state == ST_IDLE) && start && !vsync;
    assign accept     = tx_valid && tx_ready;
    assign can_load   = !tx_valid || tx_ready;
    assign launch     = ena && can_load && src_avail;
    assign in_pix     = (state == ST_PIXELS);
    assign row_end    = (col == w_span);
    assign win_end    = row_end && (row == h_span);
    assign busy       = (state != ST_IDLE);

    display_pixel_packer u_packer (
        .clk      (clk),
        .rstb     (rstb),
        .mode     (mode_q),
        .allow    (in_pix && !done),
        .final_px (win_end),
        .take     (launch && in_pix),
        .px_data  (px_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .has_byte (pk_has),
        .pix_byte (pk_byte),
        .last_byte(pk_last)
    );

    always_comb begin
        src_avail = 1'b1;
        src_byte  = 8'h00;
        src_dc    = 1'b1;
        case (state)
            ST_CASET_CMD: begin src_byte = CMD_CASET; src_dc = 1'b0; end
            ST_CASET_ARG: src_byte = arg_byte(16'(x0_q), 16'(x1_q), arg_idx);
            ST_RASET_CMD: begin src_byte = CMD_RASET; src_dc = 1'b0; end
            ST_RASET_ARG: src_byte = arg_byte(16'(y0_q), 16'(y1_q), arg_idx);
            ST_RAMWR_CMD: begin src_byte = CMD_RAMWR; src_dc = 1'b0; end
            ST_PIXELS:    begin src_avail = pk_has && !done; src_byte = pk_byte; end
            default:      src_avail = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (take_start && legal) state_nx = ST_CASET_CMD;
            ST_CASET_CMD: if (launch) state_nx = ST_CASET_ARG;
            ST_CASET_ARG: if (launch && arg_idx == 2'd3) state_nx = ST_RASET_CMD;
            ST_RASET_CMD: if (launch) state_nx = ST_RASET_ARG;
            ST_RASET_ARG: if (launch && arg_idx == 2'd3) state_nx = ST_RAMWR_CMD;
            ST_RAMWR_CMD: if (launch) state_nx = ST_PIXELS;
            ST_PIXELS:    if (accept && tx_eof) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_q        <= PIX_RGB565;
            x0_q          <= '0;
            x1_q          <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            w_span        <= '0;
            h_span        <= '0;
            col           <= '0;
            row           <= '0;
            arg_idx       <= 2'd0;
            done          <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            data_commandb <= 1'b1;
            tx_eol        <= 1'b0;
            tx_eof        <= 1'b0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
            err_window    <= 1'b0;
        end else begin
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            err_window <= 1'b0;
            if (take_start) begin
                if (legal) begin
                    x0_q    <= x0;
                    x1_q    <= x1;
                    y0_q    <= y0;
                    y1_q    <= y1;
                    w_span  <= x1 - x0;
                    h_span  <= y1 - y0;
                    mode_q  <= pixel_mode_t'(pixel_mode);
                    arg_idx <= 2'd0;
                end else begin
                    err_window <= 1'b1;
                end
            end
            // Row/window ends travel with the byte so the pulses follow its acceptance.
            if (accept) begin
                tx_valid <= 1'b0;
                hsync    <= tx_eol;
                vsync    <= tx_eof;
            end
            if (launch) begin
                tx_valid      <= 1'b1;
                tx_data       <= src_byte;
                data_commandb <= src_dc;
                tx_eol        <= in_pix && pk_last && row_end;
                tx_eof        <= in_pix && pk_last && win_end;
                if (state == ST_CASET_ARG || state == ST_RASET_ARG) arg_idx <= arg_idx + 2'd1;
                if (state == ST_RAMWR_CMD) begin
                    col  <= '0;
                    row  <= '0;
                    done <= 1'b0;
                end
                if (in_pix && pk_last) begin
                    if (win_end) done <= 1'b1;
                    else if (row_end) begin
                        col <= '0;
                        row <= row + CW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_display_window_streamer.sv
// Scoreboard bench: expected bytes are queued at start/pixel hand-off and popped as the SPI side accepts.
module tb_spi_display_window_streamer;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          ena = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic          pixel_mode = 1'b0;
    logic [23:0]   px_data = '0;
    logic          px_valid = 1'b0;
    logic          px_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          data_commandb, busy, hsync, vsync, err_window;

    spi_display_window_streamer #(.DISPLAY_WIDTH(240), .DISPLAY_HEIGHT(320), .CW(CW)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .pixel_mode(pixel_mode),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .data_commandb(data_commandb), .busy(busy), .hsync(hsync), .vsync(vsync),
        .err_window(err_window)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0]  exp_q[$];
    logic [23:0] pix_q[$];
    int rdy_mode = 0, gap_len = 0, gap_cnt = 0, cur_mode = 0;
    int cur_rows = 0, cur_np = 0, cur_bpp = 2;
    int hs_cnt = 0, vs_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int cyc = 0, last_acc = 0, vs_cyc = 0;
    logic px_take;

    always @(posedge clk) cyc++;

    task automatic push_pixel(input logic [23:0] p);
        if (cur_mode == 0) begin
            exp_q.push_back({1'b1, p[23:19], p[15:13]});
            exp_q.push_back({1'b1, p[12:10], p[7:3]});
        end else begin
            exp_q.push_back({1'b1, p[23:18], 2'b00});
            exp_q.push_back({1'b1, p[15:10], 2'b00});
            exp_q.push_back({1'b1, p[7:2], 2'b00});
        end
    endtask

    // Monitor: every valid cycle is compared with the queue head, which also proves stall stability.
    always @(negedge clk) begin
        if (rstb) begin
            if (tx_valid) begin
                if (exp_q.size() == 0) chk("extra_byte", {23'd0, data_commandb, tx_data}, 32'h1ff);
                else begin
                    chk(tx_ready ? "tx_byte" : "tx_hold", {23'd0, data_commandb, tx_data}, {23'd0, exp_q[0]});
                    if (tx_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        last_acc = cyc;
                    end
                end
            end
            if (hsync) hs_cnt++;
            if (vsync) begin
                vs_cnt++;
                vs_cyc = cyc;
                chk("busy_at_vsync", {31'd0, busy}, 0);
            end
            if (err_window) err_cnt++;
        end
    end

    always begin
        @(negedge clk);
        px_take = px_valid && px_ready && rstb;
        @(posedge clk); #1;
        if (px_take && pix_q.size() > 0) begin
            push_pixel(pix_q.pop_front());
            gap_cnt = gap_len;
        end
        if (gap_cnt > 0) begin
            gap_cnt--;
            px_valid = 1'b0;
        end else if (pix_q.size() > 0) begin
            px_valid = 1'b1;
            px_data  = pix_q[0];
        end else begin
            px_valid = 1'b0;
        end
    end

    always begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    task automatic pulse_start(input int ax0, input int ax1, input int ay0, input int ay1, input int mode);
        @(posedge clk); #1;
        x0 = CW'(ax0); x1 = CW'(ax1); y0 = CW'(ay0); y1 = CW'(ay1);
        pixel_mode = 1'(mode);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_window(input int ax0, input int ax1, input int ay0, input int ay1,
                                input int mode, input bit use_fixed, input logic [23:0] fixed_px);
        cur_mode = mode;
        cur_bpp  = (mode == 0) ? 2 : 3;
        cur_rows = ay1 - ay0 + 1;
        cur_np   = (ax1 - ax0 + 1) * cur_rows;
        hs_cnt = 0; vs_cnt = 0; acc_cnt = 0;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(ax0 >> 8)}); exp_q.push_back({1'b1, 8'(ax0)});
        exp_q.push_back({1'b1, 8'(ax1 >> 8)}); exp_q.push_back({1'b1, 8'(ax1)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(ay0 >> 8)}); exp_q.push_back({1'b1, 8'(ay0)});
        exp_q.push_back({1'b1, 8'(ay1 >> 8)}); exp_q.push_back({1'b1, 8'(ay1)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int k = 0; k < cur_np; k++) pix_q.push_back(use_fixed ? fixed_px : 24'($urandom));
        pulse_start(ax0, ax1, ay0, ay1, mode);
    endtask

    task automatic finish_window(input string tag, input bit vs_start);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (vsync) seen = 1'b1;
        end
        chk({tag, " vsync_seen"}, {31'd0, seen}, 1);
        if (vs_start && seen) begin
            #1;
            x0 = 0; x1 = 1; y0 = 0; y1 = 1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk({tag, " hsync_count"}, hs_cnt, cur_rows);
        chk({tag, " vsync_count"}, vs_cnt, 1);
        chk({tag, " queue_empty"}, exp_q.size(), 0);
        chk({tag, " byte_count"}, acc_cnt, 11 + cur_np * cur_bpp);
        chk({tag, " vsync_timing"}, vs_cyc - last_acc, 1);
        chk({tag, " idle_after"}, {30'd0, busy, tx_valid}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst tx_valid", {31'd0, tx_valid}, 0);
        chk("rst px_ready", {31'd0, px_ready}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst syncs", {29'd0, hsync, vsync, err_window}, 0);
        chk("rst dc", {31'd0, data_commandb}, 1);
        chk("rst tx_data", {24'd0, tx_data}, 0);
        rstb = 1'b1;
        ena  = 1'b1;

        start_window(2, 5, 1, 2, 0, 0, 24'h0);
        finish_window("t1", 1);

        start_window(0, 0, 0, 0, 1, 1, 24'hFF8040);
        finish_window("t2", 0);

        rdy_mode = 1;
        start_window(3, 5, 7, 8, 0, 1, 24'hFF8040);
        finish_window("t3", 0);
        start_window(100, 103, 200, 201, 1, 0, 24'h0);
        finish_window("t3b", 0);
        rdy_mode = 0;

        pulse_start(10, 4, 0, 0, 0);
        pulse_start(0, 0, 5, 320, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4 no_activity", {30'd0, busy, tx_valid}, 0);
        end
        chk("t4 err_pulses", err_cnt, 2);

        gap_len = 5;
        start_window(0, 1, 0, 1, 1, 0, 24'h0);
        begin
            bit seen;
            int held;
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (tx_valid && !data_commandb && tx_data == 8'h2B) seen = 1'b1;
            end
            chk("t5 saw_raset", {31'd0, seen}, 1);
            #1 rdy_mode = 2;
            @(negedge clk); #1;
            ena = 1'b0;
            repeat (4) @(negedge clk);
            chk("t5 pending_held", {31'd0, tx_valid}, 1);
            held = acc_cnt;
            #1 rdy_mode = 0;
            @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("t5 no_launch", {31'd0, tx_valid}, 0);
            end
            chk("t5 one_accept", acc_cnt - held, 1);
            #1 ena = 1'b1;
        end
        finish_window("t5", 0);
        gap_len = 0;

        start_window(1, 4, 10, 13, 0, 0, 24'h0);
        for (int k = 0; k < 3000 && acc_cnt < 15; k++) @(negedge clk);
        chk("t6 in_pixels", {31'd0, acc_cnt >= 15}, 1);
        #2 rstb = 1'b0;
        #1;
        chk("t6 async tx_valid", {31'd0, tx_valid}, 0);
        chk("t6 async busy", {31'd0, busy}, 0);
        chk("t6 async px_ready", {31'd0, px_ready}, 0);
        chk("t6 async dc_data", {23'd0, data_commandb, tx_data}, 32'h100);
        exp_q.delete();
        pix_q.delete();
        repeat (3) @(negedge clk);
        chk("t6 held_in_reset", {31'd0, tx_valid}, 0);
        rstb = 1'b1;
        start_window(239, 239, 319, 319, 1, 1, 24'h123456);
        finish_window("t6b", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
